// File: rtl/aes_pkg.sv
// AES key-schedule types and constants: key-length encoding, FSM states, Rcon and S-box tables.
// Pure declarations: no latency, no flow control.
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'd0,
        KL_192 = 2'd1,
        KL_256 = 2'd2,
        KL_BAD = 2'd3
    } key_len_e;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } sched_state_e;

    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (key_len_e'(kl))
            KL_128:  return 4'd4;
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (key_len_e'(kl))
            KL_128:  return 4'd10;
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte. Latency: combinational.
// Backpressure: none.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = SBOX[a];

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128/192/256 key expansion, one word per clock, with a registered round-key read port.
// Latency: 4*(Nr+1)-Nk cycles per schedule, 1-cycle reads; start outside IDLE is dropped, no backpressure.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8,
    parameter int MAX_NR = MAX_NK + 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*MAX_NK-1:0]  key,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  keys_valid,
    output logic [3:0]            nr,
    input  logic [3:0]            rk_idx,
    output logic [127:0]          rk
);

    localparam int NW = 4 * (MAX_NR + 1);
    localparam int IW = $clog2(NW);

    sched_state_e    state, state_d;
    logic [31:0]     w [NW];
    logic [IW-1:0]   i_q;
    logic [3:0]      nk_q, imod_q, rcon_q;
    logic            legal, accept, reject, last, rot;
    logic [IW-1:0]   last_i, rbase;
    logic [31:0]     prev_w, old_w, sub_in, sub_out, temp, new_w;

    assign legal  = (nk_of(key_len) != 4'd0) && (nk_of(key_len) <= 4'(MAX_NK));
    assign accept = (state == IDLE) && start && legal;
    assign reject = (state == IDLE) && start && !legal;
    assign last_i = IW'({2'b00, nr, 2'b00} + 8'd3);
    assign last   = (state == GEN) && (i_q == last_i);

    // Generation taps: previous word and the word one key-length back.
    assign prev_w = w[i_q - IW'(1)];
    assign old_w  = w[i_q - IW'(nk_q)];
    assign rot    = (imod_q == 4'd0);
    assign sub_in = rot ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .a (sub_in[8*g +: 8]),
            .y (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        temp = prev_w;
        if (rot)
            temp = sub_out ^ {RCON[rcon_q], 24'h0};
        else if (nk_q == 4'd8 && imod_q == 4'd4)
            temp = sub_out;
    end

    assign new_w = old_w ^ temp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = GEN;
            GEN:     if (last)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == GEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nk_q       <= 4'd4;
            nr         <= 4'd10;
            i_q        <= '0;
            imod_q     <= '0;
            rcon_q     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            done <= last;
            err  <= reject;
            if (accept) begin
                nk_q       <= nk_of(key_len);
                nr         <= nr_of(key_len);
                i_q        <= IW'(nk_of(key_len));
                imod_q     <= '0;
                rcon_q     <= '0;
                keys_valid <= 1'b0;
            end else if (state == GEN) begin
                i_q    <= i_q + IW'(1);
                imod_q <= (imod_q == nk_q - 4'd1) ? 4'd0 : imod_q + 4'd1;
                if (rot)  rcon_q     <= rcon_q + 4'd1;
                if (last) keys_valid <= 1'b1;
            end
        end
    end

    // Word store is deliberately unreset; keys_valid qualifies its contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < MAX_NK; j++)
                if (4'(j) < nk_of(key_len))
                    w[j] <= key[32*(MAX_NK-j)-1 -: 32];
        end else if (state == GEN) begin
            w[i_q] <= new_w;
        end
    end

    assign rbase = IW'({rk_idx, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rk <= '0;
        else if (rk_idx > nr)
            rk <= '0;
        else
            rk <= {w[rbase], w[rbase + IW'(1)], w[rbase + IW'(2)], w[rbase + IW'(3)]};
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: FIPS-197 vectors, rejection, reset and back-to-back rules.
module tb_aes_key_sched;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic         busy, done, err, keys_valid;
    logic [3:0]   nr;
    logic [127:0] rk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] val;
    } rd_t;
    rd_t sb[$];

    aes_key_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_len    (key_len),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .keys_valid (keys_valid),
        .nr         (nr),
        .rk_idx     (rk_idx),
        .rk         (rk)
    );

    always #5 clk = ~clk;

    // Drives a start and waits (bounded) for done; reports edges from acceptance to done.
    task automatic launch(input logic [1:0] kl, input logic [255:0] k,
                          output int cyc, output logic kv0, output logic busy0);
        key_len = kl;
        key     = k;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        kv0   = keys_valid;
        busy0 = busy;
        cyc   = 0;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
        rk_idx = idx;
        @(posedge clk); #1;
        v = rk;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, keys_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b required 0000", {busy, done, err, keys_valid});
        end
        checks++;
        if (nr !== 4'd10) begin errors++; $display("FAIL reset_nr: got %0d required 10", nr); end
        checks++;
        if (rk !== 128'h0) begin errors++; $display("FAIL reset_rk: got %h required 0", rk); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_aes128();
        int cyc; logic kv0, b0; logic [127:0] v; rd_t e;
        launch(2'd0, K128, cyc, kv0, b0);
        checks++;
        if (b0 !== 1'b1 || kv0 !== 1'b0) begin
            errors++; $display("FAIL a128_start: busy=%b kv=%b required busy=1 kv=0", b0, kv0);
        end
        checks++;
        if (cyc !== 40) begin errors++; $display("FAIL a128_latency: got %0d required 40", cyc); end
        checks++;
        if (nr !== 4'd10 || keys_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL a128_status: nr=%0d kv=%b busy=%b required 10 1 0", nr, keys_valid, busy);
        end
        sb.push_back('{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c});
        sb.push_back('{4'd1,  128'ha0fafe1788542cb123a339392a6c7605});
        sb.push_back('{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        sb.push_back('{4'd11, 128'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_rk(e.idx, v);
            checks++;
            if (v !== e.val) begin errors++; $display("FAIL a128_rk%0d: got %h required %h", e.idx, v, e.val); end
        end
    endtask

    task automatic test_aes192();
        int cyc; logic kv0, b0; logic [127:0] v; rd_t e;
        launch(2'd1, K192, cyc, kv0, b0);
        checks++;
        if (cyc !== 46) begin errors++; $display("FAIL a192_latency: got %0d required 46", cyc); end
        checks++;
        if (nr !== 4'd12) begin errors++; $display("FAIL a192_nr: got %0d required 12", nr); end
        sb.push_back('{4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5});
        sb.push_back('{4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5});
        sb.push_back('{4'd12, 128'he98ba06f448c773c8ecc720401002202});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_rk(e.idx, v);
            checks++;
            if (v !== e.val) begin errors++; $display("FAIL a192_rk%0d: got %h required %h", e.idx, v, e.val); end
        end
    endtask

    task automatic test_aes256();
        int cyc; logic kv0, b0; logic [127:0] v; rd_t e;
        launch(2'd2, K256, cyc, kv0, b0);
        checks++;
        if (cyc !== 52) begin errors++; $display("FAIL a256_latency: got %0d required 52", cyc); end
        checks++;
        if (nr !== 4'd14 || keys_valid !== 1'b1) begin
            errors++; $display("FAIL a256_status: nr=%0d kv=%b required 14 1", nr, keys_valid);
        end
        sb.push_back('{4'd1,  128'h1f352c073b6108d72d9810a30914dff4});
        sb.push_back('{4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde});
        sb.push_back('{4'd14, 128'hfe4890d1e6188d0b046df344706c631e});
        sb.push_back('{4'd15, 128'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_rk(e.idx, v);
            checks++;
            if (v !== e.val) begin errors++; $display("FAIL a256_rk%0d: got %h required %h", e.idx, v, e.val); end
        end
    endtask

    task automatic test_reject();
        logic [127:0] v;
        key_len = 2'd3;
        key     = K128;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b1) begin
            errors++; $display("FAIL reject_pulse: err=%b busy=%b kv=%b required 1 0 1", err, busy, keys_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || nr !== 4'd14) begin
            errors++; $display("FAIL reject_after: err=%b nr=%0d required 0 14", err, nr);
        end
        read_rk(4'd14, v);
        checks++;
        if (v !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            errors++; $display("FAIL reject_store: got %h required fe4890d1e6188d0b046df344706c631e", v);
        end
    endtask

    task automatic test_mid_start();
        int cyc; logic err_seen; logic [127:0] v;
        key_len = 2'd0;
        key     = K128;
        start   = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        cyc      = 0;
        err_seen = 1'b0;
        while (!done && cyc < 300) begin
            if (cyc == 10) begin start = 1'b1; key_len = 2'd2; key = K256; end
            else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (err) err_seen = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (cyc !== 40 || err_seen !== 1'b0) begin
            errors++; $display("FAIL mid_start: cycles=%0d err_seen=%b required 40 0", cyc, err_seen);
        end
        checks++;
        if (nr !== 4'd10) begin errors++; $display("FAIL mid_start_nr: got %0d required 10", nr); end
        read_rk(4'd10, v);
        checks++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++; $display("FAIL mid_start_rk10: got %h required d014f9a8c9ee2589e13f0cc8b6630ca6", v);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic kv0, b0; logic [127:0] v;
        key_len = 2'd2;
        key     = K256;
        rk_idx  = 4'd14;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, keys_valid} !== 4'b0000 || nr !== 4'd10 || rk !== 128'h0) begin
            errors++; $display("FAIL reset_mid: flags=%b nr=%0d rk=%h required 0000 10 0",
                               {busy, done, err, keys_valid}, nr, rk);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || keys_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_resume: busy=%b kv=%b required 0 0", busy, keys_valid);
        end
        launch(2'd0, K128, cyc, kv0, b0);
        checks++;
        if (cyc !== 40) begin errors++; $display("FAIL restart_latency: got %0d required 40", cyc); end
        read_rk(4'd10, v);
        checks++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++; $display("FAIL restart_rk10: got %h required d014f9a8c9ee2589e13f0cc8b6630ca6", v);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic kv0, b0; logic [127:0] v;
        launch(2'd0, K128, cyc, kv0, b0);
        checks++;
        if (done !== 1'b1 || cyc !== 40) begin
            errors++; $display("FAIL b2b_first: done=%b cycles=%0d required 1 40", done, cyc);
        end
        launch(2'd2, K256, cyc, kv0, b0);
        checks++;
        if (kv0 !== 1'b0 || b0 !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: kv=%b busy=%b required 0 1", kv0, b0);
        end
        checks++;
        if (cyc !== 52 || nr !== 4'd14) begin
            errors++; $display("FAIL b2b_second: cycles=%0d nr=%0d required 52 14", cyc, nr);
        end
        read_rk(4'd14, v);
        checks++;
        if (v !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            errors++; $display("FAIL b2b_rk14: got %h required fe4890d1e6188d0b046df344706c631e", v);
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_reject();
        test_mid_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
